// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage driving the register-file write port, with load extraction and retire counting
module writeback_unit #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wr_en,
    input  logic        in_is_load,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic        wr_en,
    output logic [31:0] rd,
    output logic [31:0] result,
    output logic        load_err,
    output logic [31:0] retire_count
);
    localparam logic IDLE      = 1'b0;
    localparam logic WAIT_LOAD = 1'b1;

    logic        state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [31:0] retire_q, retire_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;
    logic        bad_v;

    assign in_ready     = (state_q == IDLE);
    assign wr_en        = wr_en_q;
    assign rd           = {27'b0, rd_q};
    assign result       = result_q;
    assign load_err     = err_q;
    assign retire_count = retire_q;

    // Pick the addressed byte/half of the returned word, extend it, and flag misaligned or illegal loads
    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_v  = (f3_q == 3'b000) ? {{24{byte_v[7]}}, byte_v} :
                 (f3_q == 3'b100) ? {24'b0, byte_v} :
                 (f3_q == 3'b001) ? {{16{half_v[15]}}, half_v} :
                 (f3_q == 3'b101) ? {16'b0, half_v} : mem_rdata;
        bad_v  = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) ||
                 ((f3_q[1:0] == 2'b01) && off_q[0]) ||
                 ((f3_q == 3'b010) && (off_q != 2'b00));
    end

    // Next-state: accept in IDLE, wait for load data or time out in WAIT_LOAD
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_rd_d  = ld_rd_q;
        f3_d     = f3_q;
        off_d    = off_q;
        wr_en_d  = 1'b0;
        rd_d     = rd_q;
        result_d = result_q;
        err_d    = 1'b0;
        retire_d = retire_q;
        if (state_q == IDLE) begin
            if (in_valid && in_is_load) begin
                ld_rd_d = in_rd;
                f3_d    = in_funct3;
                off_d   = in_alu_result[1:0];
                cnt_d   = 8'd0;
                state_d = WAIT_LOAD;
            end else if (in_valid) begin
                wr_en_d  = in_wr_en && (in_rd != 5'd0);
                rd_d     = in_rd;
                result_d = in_alu_result;
                retire_d = retire_q + 32'd1;
            end
        end else if (mem_rdata_valid) begin
            state_d = IDLE;
            if (bad_v) begin
                err_d = 1'b1;
            end else begin
                wr_en_d  = (ld_rd_q != 5'd0);
                rd_d     = ld_rd_q;
                result_d = ext_v;
                retire_d = retire_q + 32'd1;
            end
        end else if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            ld_rd_q  <= 5'd0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            wr_en_q  <= 1'b0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_rd_q  <= ld_rd_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            wr_en_q  <= wr_en_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            err_q    <= err_d;
            retire_q <= retire_d;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized self-checking bench for writeback_unit against a behavioural model
module tb_writeback_unit;
    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr_en;
    logic        in_is_load;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic        mem_rdata_valid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [31:0] rd;
    logic [31:0] result;
    logic        load_err;
    logic [31:0] retire_count;

    int tests = 0;
    int fails = 0;
    logic        m_wr, m_err;
    logic [31:0] m_rd, m_res, m_ret;

    writeback_unit #(.LOAD_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_en(in_wr_en), .in_is_load(in_is_load), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .wr_en(wr_en), .rd(rd), .result(result), .load_err(load_err),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load semantics from access size: alignment is offset modulo size, value is shifted and masked
    task automatic ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w,
                            output logic err, output logic [31:0] v);
        int sz;
        logic [31:0] mask;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((int'(off) % sz) != 0);
        v = w >> (8 * int'(off));
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_err = 0; m_rd = 0; m_res = 0; m_ret = 0;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_wr_en = 0; in_is_load = 0; in_rd = 0; in_funct3 = 0;
        in_alu_result = 0; mem_rdata_valid = 0; mem_rdata = 0;
        tick(); tick();
        rst = 0;
        model_reset();
    endtask

    task automatic send_alu(input logic w, input logic [4:0] r, input logic [31:0] val, input string tag);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s ready_before: got %b exp 1", tag, in_ready); end
        in_valid = 1; in_is_load = 0; in_wr_en = w; in_rd = r; in_funct3 = 3'($urandom);
        in_alu_result = val; mem_rdata_valid = 1'($urandom); mem_rdata = $urandom;
        tick();
        in_valid = 0; mem_rdata_valid = 0;
        m_wr = w && (r != 0); m_rd = {27'b0, r}; m_res = val; m_ret = m_ret + 1; m_err = 0;
        tests += 6;
        if (wr_en !== m_wr) begin fails++; $display("FAIL %s wr_en: got %b exp %b", tag, wr_en, m_wr); end
        if (rd !== m_rd) begin fails++; $display("FAIL %s rd: got %0d exp %0d", tag, rd, m_rd); end
        if (result !== m_res) begin fails++; $display("FAIL %s result: got %h exp %h", tag, result, m_res); end
        if (load_err !== 1'b0) begin fails++; $display("FAIL %s load_err: got %b exp 0", tag, load_err); end
        if (retire_count !== m_ret) begin fails++; $display("FAIL %s retire: got %0d exp %0d", tag, retire_count, m_ret); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s ready_after: got %b exp 1", tag, in_ready); end
    endtask

    task automatic send_load(input logic [2:0] f3, input logic [1:0] off, input int delay,
                             input logic [31:0] word, input logic [4:0] r, input string tag);
        logic [31:0] a, v;
        logic e;
        ref_load(f3, off, word, e, v);
        a = $urandom; a[1:0] = off;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s ready_before: got %b exp 1", tag, in_ready); end
        in_valid = 1; in_is_load = 1; in_wr_en = 1'($urandom); in_rd = r; in_funct3 = f3; in_alu_result = a;
        mem_rdata_valid = 0;
        tick();
        in_valid = 0; in_funct3 = 3'($urandom); in_rd = 5'($urandom);
        for (int i = 0; i <= delay; i++) begin
            tests += 3;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL %s wait_ready[%0d]: got %b exp 0", tag, i, in_ready); end
            if (wr_en !== 1'b0) begin fails++; $display("FAIL %s wait_wr_en[%0d]: got %b exp 0", tag, i, wr_en); end
            if (load_err !== 1'b0) begin fails++; $display("FAIL %s wait_err[%0d]: got %b exp 0", tag, i, load_err); end
            if (i < delay) tick();
        end
        mem_rdata_valid = 1; mem_rdata = word;
        tick();
        mem_rdata_valid = 0; mem_rdata = $urandom;
        if (e) begin
            m_wr = 0; m_err = 1;
        end else begin
            m_wr = (r != 0); m_err = 0; m_rd = {27'b0, r}; m_res = v; m_ret = m_ret + 1;
        end
        tests += 6;
        if (wr_en !== m_wr) begin fails++; $display("FAIL %s wr_en: got %b exp %b", tag, wr_en, m_wr); end
        if (rd !== m_rd) begin fails++; $display("FAIL %s rd: got %0d exp %0d", tag, rd, m_rd); end
        if (result !== m_res) begin fails++; $display("FAIL %s result: got %h exp %h", tag, result, m_res); end
        if (load_err !== m_err) begin fails++; $display("FAIL %s load_err: got %b exp %b", tag, load_err, m_err); end
        if (retire_count !== m_ret) begin fails++; $display("FAIL %s retire: got %0d exp %0d", tag, retire_count, m_ret); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s ready_after: got %b exp 1", tag, in_ready); end
    endtask

    task automatic test_reset();
        do_reset();
        tests += 6;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b exp 1", in_ready); end
        if (wr_en !== 1'b0) begin fails++; $display("FAIL reset wr_en: got %b exp 0", wr_en); end
        if (rd !== 32'd0) begin fails++; $display("FAIL reset rd: got %0d exp 0", rd); end
        if (result !== 32'd0) begin fails++; $display("FAIL reset result: got %h exp 0", result); end
        if (load_err !== 1'b0) begin fails++; $display("FAIL reset load_err: got %b exp 0", load_err); end
        if (retire_count !== 32'd0) begin fails++; $display("FAIL reset retire: got %0d exp 0", retire_count); end
    endtask

    task automatic test_alu_basic();
        send_alu(1'b1, 5'd5, 32'h1234_5678, "alu_basic");
        tests++;
        if (retire_count !== 32'd1) begin fails++; $display("FAIL alu_basic retire_const: got %0d exp 1", retire_count); end
    endtask

    task automatic test_load_plan();
        send_load(3'b000, 2'd2, 3, 32'h0080_0000, 5'd7, "lb_off2");
        tests++;
        if (result !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_off2 result_const: got %h exp ffffff80", result); end
        send_load(3'b101, 2'd2, 1, 32'hBEEF_0000, 5'd9, "lhu_off2");
        tests++;
        if (result !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_off2 result_const: got %h exp 0000beef", result); end
        send_load(3'b001, 2'd1, 0, 32'h1234_5678, 5'd3, "lh_off1");
        tests++;
        if (load_err !== 1'b1) begin fails++; $display("FAIL lh_off1 err_const: got %b exp 1", load_err); end
        tick();
        tests++;
        if (load_err !== 1'b0) begin fails++; $display("FAIL lh_off1 err_pulse: got %b exp 0", load_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        a = $urandom;
        in_valid = 1; in_is_load = 1; in_rd = 5'd4; in_funct3 = 3'b010; in_alu_result = {a[31:2], 2'b00};
        tick();
        in_valid = 0;
        for (int i = 1; i <= LT; i++) begin
            tick();
            tests += 2;
            if (load_err !== (i == LT)) begin fails++; $display("FAIL timeout err[%0d]: got %b exp %b", i, load_err, (i == LT)); end
            if (in_ready !== (i == LT)) begin fails++; $display("FAIL timeout ready[%0d]: got %b exp %b", i, in_ready, (i == LT)); end
        end
        tests += 2;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL timeout wr_en: got %b exp 0", wr_en); end
        if (retire_count !== m_ret) begin fails++; $display("FAIL timeout retire: got %0d exp %0d", retire_count, m_ret); end
        tick();
        tests++;
        if (load_err !== 1'b0) begin fails++; $display("FAIL timeout err_pulse: got %b exp 0", load_err); end
        m_err = 0; m_wr = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_alu(1'b1, 5'd0, 32'hDEAD_BEEF, "b2b_x0");
        for (int i = 0; i < 10; i++) send_alu(1'b1, 5'(i + 1), $urandom, "b2b");
        tests++;
        if (retire_count !== 32'd11) begin fails++; $display("FAIL b2b retire_const: got %0d exp 11", retire_count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0)
                send_alu(1'($urandom), 5'($urandom), $urandom, "rand_alu");
            else
                send_load(3'($urandom), 2'($urandom), int'($urandom_range(0, LT - 1)), $urandom, 5'($urandom), "rand_load");
            if ($urandom_range(0, 3) == 0) begin
                tick();
                m_wr = 0; m_err = 0;
                tests += 2;
                if (wr_en !== 1'b0) begin fails++; $display("FAIL rand_idle wr_en: got %b exp 0", wr_en); end
                if (load_err !== 1'b0) begin fails++; $display("FAIL rand_idle err: got %b exp 0", load_err); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        send_load(3'b010, 2'd0, 0, 32'h1111_2222, 5'd6, "pre_rst");
        in_valid = 1; in_is_load = 1; in_rd = 5'd8; in_funct3 = 3'b010; in_alu_result = 32'h100;
        tick();
        in_valid = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        mem_rdata_valid = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rdata_valid = 0;
        tests += 6;
        if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_mid wr_en: got %b exp 0", wr_en); end
        if (load_err !== 1'b0) begin fails++; $display("FAIL rst_mid load_err: got %b exp 0", load_err); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid ready: got %b exp 1", in_ready); end
        if (retire_count !== m_ret) begin fails++; $display("FAIL rst_mid retire: got %0d exp %0d", retire_count, m_ret); end
        if (rd !== m_rd) begin fails++; $display("FAIL rst_mid rd: got %0d exp %0d", rd, m_rd); end
        if (result !== m_res) begin fails++; $display("FAIL rst_mid result: got %h exp %h", result, m_res); end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_load_plan();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
